// File: rtl/mesi_pkg.sv
// Shared MESI coherence types: bus command encodings, request types and
// the agent FSM state encodings. Also used by mesi_isc and its checkers.
package mesi_pkg;

  typedef enum logic [2:0] {
    MBUS_NOP      = 3'd0,
    MBUS_WR       = 3'd1,
    MBUS_RD       = 3'd2,
    MBUS_WR_BROAD = 3'd3,
    MBUS_RD_BROAD = 3'd4
  } mbus_cmd_t;

  typedef enum logic [2:0] {
    CBUS_NOP      = 3'd0,
    CBUS_WR_SNOOP = 3'd1,
    CBUS_RD_SNOOP = 3'd2,
    CBUS_EN_WR    = 3'd3,
    CBUS_EN_RD    = 3'd4
  } cbus_cmd_t;

  typedef enum logic [1:0] {
    BREQ_NOP = 2'd0,
    BREQ_WR  = 2'd1,
    BREQ_RD  = 2'd2
  } breq_type_t;

  typedef enum logic [2:0] {
    R_IDLE    = 3'd0,
    R_BROAD   = 3'd1,
    R_WAIT_EN = 3'd2,
    R_ACCESS  = 3'd3,
    R_DONE    = 3'd4
  } req_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } snp_state_t;

  // Encodings 5..7 on the coherence bus have no meaning.
  function automatic logic cbus_is_reserved(input logic [2:0] cmd);
    return cmd > 3'd4;
  endfunction

endpackage

// File: rtl/mesi_agent_snoop.sv
// Snoop half of the core agent: captures a snoop from the coherence bus,
// presents it to the local cache, acknowledges once the cache is done and
// then sits out one cycle while mesi_isc drops the command.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for WR_SNOOP / RD_SNOOP (unless blocked by enable ack)
// S_WAIT | snoop presented to cache, waiting for snoop_done_i
// S_ACK  | snoop_ack_o high for one cycle
// S_HOLD | command still on cbus after ack; ignore it
module mesi_agent_snoop
  import mesi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
  input  logic                  cmd_block_i,
  input  logic                  snoop_done_i,
  output logic                  snoop_valid_o,
  output logic                  snoop_wr_o,
  output logic [ADDR_WIDTH-1:0] snoop_addr_o,
  output logic                  snoop_ack_o,
  output logic                  snoop_idle_o
);

  snp_state_t            r_state;
  snp_state_t            w_state_nxt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_take;
  logic                  w_valid;
  logic                  w_ack;

  // The enable path owns the bus while its own ack/holdoff is in flight.
  assign w_take = (r_state == S_IDLE) && !cmd_block_i &&
                  ((cbus_cmd_i == CBUS_WR_SNOOP) || (cbus_cmd_i == CBUS_RD_SNOOP));

  // Snoop state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture snoop type and address when a snoop is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
    end else if (w_take) begin
      r_wr   <= (cbus_cmd_i == CBUS_WR_SNOOP);
      r_addr <= cbus_addr_i;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: if (w_take) w_state_nxt = S_WAIT;
      S_WAIT: begin
        w_valid = 1'b1;
        if (snoop_done_i) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign snoop_valid_o = w_valid;
  assign snoop_wr_o    = w_valid & r_wr;
  assign snoop_addr_o  = w_valid ? r_addr : '0;
  assign snoop_ack_o   = w_ack;
  assign snoop_idle_o  = (r_state == S_IDLE);

endmodule

// File: rtl/mesi_core_agent.sv
// Per-core coherence agent downstream of mesi_isc. Converts a cache
// miss/upgrade into broadcast + access on the main bus, and answers every
// snoop/enable on the coherence bus with exactly one ack pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// R_IDLE    | ready for a cache request
// R_BROAD   | WR_BROAD/RD_BROAD on mbus until mbus_ack_i
// R_WAIT_EN | mbus idle, waiting for matching EN_WR/EN_RD (then +1 cycle)
// R_ACCESS  | WR/RD on mbus until mbus_ack_i
// R_DONE    | done_o pulse
module mesi_core_agent
  import mesi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  done_o,
  output logic [2:0]            mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0] mbus_addr_o,
  input  logic                  mbus_ack_i,
  input  logic [2:0]            cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
  output logic                  cbus_ack_o,
  output logic                  snoop_valid_o,
  output logic                  snoop_wr_o,
  output logic [ADDR_WIDTH-1:0] snoop_addr_o,
  input  logic                  snoop_done_i,
  output logic                  err_o
);

  req_state_t            r_state;
  req_state_t            w_state_nxt;
  breq_type_t            r_type;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_en_ack;
  logic                  r_en_hold;
  logic                  r_en_go;
  logic                  r_err;
  mbus_cmd_t             w_mbus_cmd;
  logic                  w_done;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_snoop_idle;
  logic                  w_snoop_ack;
  logic                  w_cbus_free;
  logic                  w_is_en;
  logic                  w_en_match;
  logic                  w_en_ok;
  logic                  w_is_rsvd;

  assign w_accept = (r_state == R_IDLE) && req_valid_i;

  // The cbus is only decoded when no snoop is in flight and no enable
  // ack/holdoff is pending, so a held command is never acked twice.
  assign w_cbus_free = w_snoop_idle && !r_en_ack && !r_en_hold;
  assign w_is_en     = w_cbus_free &&
                       ((cbus_cmd_i == CBUS_EN_WR) || (cbus_cmd_i == CBUS_EN_RD));
  assign w_en_match  = (cbus_cmd_i == CBUS_EN_WR) ? (r_type == BREQ_WR)
                                                  : (r_type == BREQ_RD);
  assign w_en_ok     = w_is_en && (r_state == R_WAIT_EN) && w_en_match;
  assign w_is_rsvd   = w_cbus_free && cbus_is_reserved(cbus_cmd_i);

  // Request state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch request type and address on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_type <= BREQ_NOP;
      r_addr <= '0;
    end else if (w_accept) begin
      r_type <= req_wr_i ? BREQ_WR : BREQ_RD;
      r_addr <= req_addr_i;
    end
  end

  // Enable ack, one-cycle holdoff behind it, and sticky protocol error.
  // r_en_go delays the move to R_ACCESS so the access starts after the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_ack  <= 1'b0;
      r_en_hold <= 1'b0;
      r_en_go   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_en_ack  <= w_is_en;
      r_en_hold <= r_en_ack;
      r_en_go   <= w_en_ok;
      if ((w_is_en && !w_en_ok) || w_is_rsvd) r_err <= 1'b1;
    end
  end

  // Request next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_mbus_cmd  = MBUS_NOP;
    w_done      = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      R_IDLE: begin
        w_ready = 1'b1;
        if (req_valid_i) w_state_nxt = R_BROAD;
      end
      R_BROAD: begin
        if (r_type == BREQ_WR) w_mbus_cmd = MBUS_WR_BROAD;
        else                   w_mbus_cmd = MBUS_RD_BROAD;
        if (mbus_ack_i) w_state_nxt = R_WAIT_EN;
      end
      R_WAIT_EN: begin
        if (r_en_go) w_state_nxt = R_ACCESS;
      end
      R_ACCESS: begin
        if (r_type == BREQ_WR) w_mbus_cmd = MBUS_WR;
        else                   w_mbus_cmd = MBUS_RD;
        if (mbus_ack_i) w_state_nxt = R_DONE;
      end
      R_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = R_IDLE;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  mesi_agent_snoop #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_snoop (
    .clk           (clk),
    .rst           (rst),
    .cbus_cmd_i    (cbus_cmd_i),
    .cbus_addr_i   (cbus_addr_i),
    .cmd_block_i   (r_en_ack | r_en_hold),
    .snoop_done_i  (snoop_done_i),
    .snoop_valid_o (snoop_valid_o),
    .snoop_wr_o    (snoop_wr_o),
    .snoop_addr_o  (snoop_addr_o),
    .snoop_ack_o   (w_snoop_ack),
    .snoop_idle_o  (w_snoop_idle)
  );

  assign req_ready_o = w_ready;
  assign done_o      = w_done;
  assign mbus_cmd_o  = w_mbus_cmd;
  assign mbus_addr_o = (w_mbus_cmd != MBUS_NOP) ? r_addr : '0;
  assign cbus_ack_o  = r_en_ack | w_snoop_ack;
  assign err_o       = r_err;

endmodule
